// File: rtl/instruction_decoder_pkg.sv
// rtl/instruction_decoder_pkg.sv - shared RV32I/RV64I decode types, field codes and the decoded record
package instruction_decoder_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [6:0] {
    OP_LOAD      = 7'b0000011,
    OP_MISC_MEM  = 7'b0001111,
    OP_ARITH_IMM = 7'b0010011,
    OP_AUIPC     = 7'b0010111,
    OP_STORE     = 7'b0100011,
    OP_ARITH     = 7'b0110011,
    OP_LUI       = 7'b0110111,
    OP_BRANCH    = 7'b1100011,
    OP_JALR      = 7'b1100111,
    OP_JAL       = 7'b1101111,
    OP_SYSTEM    = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7
  } branch_funct3_e;

  typedef enum logic [2:0] {
    F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LD = 3'd3, F3_LBU = 3'd4, F3_LHU = 3'd5, F3_LWU = 3'd6
  } load_funct3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2, F3_SD = 3'd3
  } store_funct3_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3,
    F3_XOR = 3'd4, F3_SRL_SRA = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7
  } arith_funct3_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY, ST_ONE, ST_TWO
  } skid_state_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [MAX_XLEN-1:0] imm;
    logic                rs1_used;
    logic                rs2_used;
    logic                rd_written;
    logic                illegal;
  } decoded_instr_t;

endpackage

// File: rtl/immediate_generator.sv
// rtl/immediate_generator.sv - reassembles the format-specific immediate, sign-extended to XLEN
module immediate_generator
  import instruction_decoder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Every format carries its sign in bit 31, so widening the 32-bit form is enough.
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - RV32I/RV64I decode stage with optional two-entry skid buffer and flush
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_written,
  output logic            out_illegal
);

  localparam logic RV32 = (XLEN == 32);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  imm_type_e       imm_type;
  logic            illegal;
  logic            rs1_used;
  logic            rs2_used;
  logic            rd_used;
  logic [XLEN-1:0] imm;
  decoded_instr_t  dec;
  decoded_instr_t  out_d, out_q;
  decoded_instr_t  skid_d, skid_q;
  skid_state_e     state_d, state_q;
  logic            out_valid_d, out_valid_q;
  logic            in_ready_d, in_ready_q;
  logic            in_xfer;
  logic            out_xfer;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];

  immediate_generator #(.XLEN(XLEN)) u_imm_gen (
    .instr    (in_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  always_comb begin
    illegal  = 1'b0;
    imm_type = IMM_NONE;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    rd_used  = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm_type = IMM_U;
        rs1_used = 1'b0;
      end
      OP_JAL: begin
        imm_type = IMM_J;
        rs1_used = 1'b0;
      end
      OP_JALR: begin
        imm_type = IMM_I;
        illegal  = (funct3 != 3'd0);
      end
      OP_BRANCH: begin
        imm_type = IMM_B;
        rs2_used = 1'b1;
        rd_used  = 1'b0;
        illegal  = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        imm_type = IMM_I;
        illegal  = (funct3 == 3'd7) || (RV32 && (funct3 == F3_LD || funct3 == F3_LWU));
      end
      OP_STORE: begin
        imm_type = IMM_S;
        rs2_used = 1'b1;
        rd_used  = 1'b0;
        illegal  = funct3[2] || (RV32 && funct3 == F3_SD);
      end
      OP_ARITH_IMM: begin
        imm_type = IMM_I;
        // Shift-immediates: bits above shamt must be zero (or 010000 for SRAI); shamt[5] only exists on RV64.
        if (funct3 == F3_SLL)
          illegal = (in_instr[31:26] != 6'b000000) || (RV32 && in_instr[25]);
        else if (funct3 == F3_SRL_SRA)
          illegal = ((in_instr[31:26] != 6'b000000) && (in_instr[31:26] != 6'b010000))
                    || (RV32 && in_instr[25]);
      end
      OP_ARITH: begin
        rs2_used = 1'b1;
        illegal  = !((funct7 == 7'h00) ||
                     (funct7 == 7'h20 && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
      end
      OP_MISC_MEM, OP_SYSTEM: begin
        imm_type = (opcode == OP_SYSTEM) ? IMM_I : IMM_NONE;
      end
      default: illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) illegal = 1'b1;
  end

  always_comb begin
    dec            = '0;
    dec.pc         = MAX_XLEN'(in_pc);
    dec.opcode     = opcode;
    dec.rd         = rd;
    dec.rs1        = in_instr[19:15];
    dec.rs2        = in_instr[24:20];
    dec.funct3     = funct3;
    dec.funct7     = funct7;
    dec.imm        = MAX_XLEN'(imm);
    dec.rs1_used   = rs1_used && !illegal;
    dec.rs2_used   = rs2_used && !illegal;
    dec.rd_written = rd_used && !illegal && (rd != 5'd0);
    dec.illegal    = illegal;
  end

  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = out_valid_q && out_ready;

  // TWO is only reachable with SKID=1; without it in_ready already implies out_ready when full.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) begin
          state_d = ST_ONE;
          out_d   = dec;
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_d = dec;
          end else if (in_xfer) begin
            state_d = ST_TWO;
            skid_d  = dec;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (out_xfer) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_q.pc[XLEN-1:0];
  assign out_opcode     = out_q.opcode;
  assign out_rd         = out_q.rd;
  assign out_rs1        = out_q.rs1;
  assign out_rs2        = out_q.rs2;
  assign out_funct3     = out_q.funct3;
  assign out_funct7     = out_q.funct7;
  assign out_imm        = out_q.imm[XLEN-1:0];
  assign out_rs1_used   = out_q.rs1_used;
  assign out_rs2_used   = out_q.rs2_used;
  assign out_rd_written = out_q.rd_written;
  assign out_illegal    = out_q.illegal;

  if (XLEN < MAX_XLEN) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{out_q.pc[MAX_XLEN-1:XLEN], out_q.imm[MAX_XLEN-1:XLEN]};
  end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Pipelined RV32I/RV64I base-integer decode stage between fetch and register-read/execute. Accepts raw 32-bit instruction words with their PC over a valid/ready handshake. Emits a decoded record with fields split out, the immediate reassembled and sign-extended to XLEN, source-usage flags and an illegal-instruction flag. Generalises the shared instruction-format types to parametrised XLEN and optional registered-ready (skid) buffering, and adds flush.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sizes `in_pc`, `out_pc`, `out_imm`.
- SKID, 0, 0: single output register, combinational `in_ready`; 1: two-entry skid buffer, `in_ready` driven from a flop.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all buffered entries; any input handshake in the same cycle is dropped.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of `in_instr`.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  passed-through PC.
- out_opcode  out  7  OpCode enum.
- out_rd, out_rs1, out_rs2  out  5 each  register indices (raw bit fields).
- out_funct3  out  3  funct3 field.
- out_funct7  out  7  funct7 field.
- out_imm  out  XLEN  sign-extended immediate, 0 for R-type/unused.
- out_rs1_used, out_rs2_used, out_rd_written  out  1 each  operand usage; `out_rd_written` is 0 when rd=x0.
- out_illegal  out  1  word is not a supported base-ISA instruction.

## Operation
- Transfer: `in_valid && in_ready` at a rising edge; output transfer: `out_valid && out_ready`.
- Immediates, taken from instr bits and sign-extended from bit 31 to XLEN:
  - I-type (LOAD, ARITH_IMM, JALR, SYSTEM): [31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - U-type (LUI, AUIPC): {[31:12],12'b0}.
  - J-type: {[31],[19:12],[20],[30:21],0}.
- Illegal when any of the following holds:
  - instr[1:0]≠2'b11.
  - Opcode is outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ARITH_IMM, ARITH, MISC_MEM, SYSTEM}; FP and atomic opcodes are illegal.
  - BRANCH funct3∈{2,3}.
  - JALR funct3≠0.
  - LOAD funct3∈{7}, or funct3∈{3,6} when XLEN=32.
  - STORE funct3>3, or funct3=3 when XLEN=32.
  - ARITH funct7∉{0x00,0x20}, or funct7=0x20 with funct3∉{0,5}.
  - SLLI/SRLI/SRAI upper bits invalid; shamt[5]=1 is illegal when XLEN=32.
- Illegal words are still forwarded, with `out_illegal`=1 and usage flags 0; they do not stall.
- Usage flags are derived per opcode: rs2 used for BRANCH/STORE/ARITH; rs1 used for all except LUI/AUIPC/JAL.

## Timing
- Reset: `out_valid`=0; all `out_*` data=0; `in_ready`=1; skid state EMPTY.
- SKID=0:
  - Latency 1 cycle.
  - `in_ready = !out_valid || out_ready`.
  - Full throughput with no bubbles.
- SKID=1 state machine:
  - EMPTY →(in xfer)→ ONE.
  - ONE →(in xfer, no out xfer)→ TWO.
  - ONE →(out xfer, no in xfer)→ EMPTY.
  - ONE stays ONE on simultaneous in/out transfers.
  - TWO →(out xfer)→ ONE; the skid entry moves to the output register.
  - `in_ready` is registered and equals (state≠TWO). Latency 1 cycle, order preserved.
- Flush:
  - Next state is EMPTY with `out_valid`=0.
  - An output transfer occurring in the flush cycle still counts.
  - `in_ready`=1 the following cycle.
- Output data are stable while `out_valid && !out_ready`.
- Reset asserted mid-operation clears all entries immediately (asynchronously).

## Structure
- Shared package gets: `XLEN`-independent enums (OpCode, funct3 enums, plus new LOAD LD/LWU and STORE SD codes), a `decoded_instr_t` packed struct parametrised via a package localparam `MAX_XLEN=64`, and an `imm_type_e` enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- One combinational sub-module, `immediate_generator`: inputs are the instruction and `imm_type_e`; output is the XLEN immediate.
- Decode logic and the skid FSM stay in `instruction_decoder`.

## Test plan
- XLEN=32, SKID=0: in 0xFFF00093 (addi x1,x0,-1) → out_imm=0xFFFFFFFF, rd=1, rs1=0, rs1_used=1, illegal=0, one cycle later.
- 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, rs2_used=1, rd_written=0. 0x001000EF (jal x1,2048) → imm=0x00000800. 0x123452B7 (lui x5) → imm=0x12345000; with XLEN=64 an input of 0x800002B7 gives imm=0xFFFFFFFF80000000.
- Illegal: 0x00000000, 0x02000033 (funct7=1), and 0x00003003 (LD) at XLEN=32 → out_illegal=1 each, forwarded in order; the same LD at XLEN=64 → illegal=0.
- SKID=1: stream of 8 words with out_ready low for 3 cycles → `in_ready` falls only after 2 words are buffered, no loss or duplication, order preserved, full rate once ready rises.
- Flush while in state TWO with in_valid=1 → next cycle out_valid=0 and in_ready=1, dropped word never appears; rst_n pulsed low mid-stream → outputs zero immediately.
